// File: rtl/rv32i_types.sv
// Shared types for the RV32I out-of-order core: the CDB broadcast and the reorder-buffer entry and commit bundles.
package rv32i_types;

  localparam int ROB_IDX_WIDTH = 5;
  localparam int ROB_DEPTH     = 1 << ROB_IDX_WIDTH;

  typedef struct packed {
    logic                     valid;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic [31:0]              data;
  } cdb;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic [31:0] data;
  } rob_entry_t;

  typedef struct packed {
    logic                     valid;
    logic [4:0]               rd_addr;
    logic [31:0]              data;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic                     regf_we;
  } rob_commit_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: allocates entries at dispatch, captures CDB results and retires them in program order.
// Optional synchronous flush is enabled with the ROB_FLUSH_EN macro.
module rob
  import rv32i_types::*;
#(
  parameter int ROB_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dispatch_valid,
  input  logic [4:0]               dispatch_rd_addr,
  input  logic                     dispatch_regf_we,
  output logic                     dispatch_ready,
  output logic [ROB_IDX_WIDTH-1:0] alloc_rob_idx,
  input  cdb                       cdbus,
  output logic                     commit_valid,
  output logic [4:0]               commit_rd_addr,
  output logic [31:0]              commit_data,
  output logic [ROB_IDX_WIDTH-1:0] commit_rob_idx,
  output logic                     commit_regf_we,
  output logic                     full,
  output logic                     empty
`ifdef ROB_FLUSH_EN
  ,
  input  logic                     flush
`endif
);

  localparam int DEPTH = 1 << ROB_IDX_WIDTH;

  // Handshake: an entry is allocated on any edge where dispatch_valid && dispatch_ready;
  // dispatch_ready depends on registered state only, so the dispatcher holds while it is low.
  rob_entry_t                entries [DEPTH];
  logic [ROB_IDX_WIDTH:0]    head;
  logic [ROB_IDX_WIDTH:0]    tail;
  logic [ROB_IDX_WIDTH-1:0]  head_idx;
  logic [ROB_IDX_WIDTH-1:0]  tail_idx;
  logic                      alloc;
  rob_commit_t               commit;

  assign head_idx       = head[ROB_IDX_WIDTH-1:0];
  assign tail_idx       = tail[ROB_IDX_WIDTH-1:0];
  assign empty          = (head == tail);
  assign full           = (head_idx == tail_idx) && (head[ROB_IDX_WIDTH] != tail[ROB_IDX_WIDTH]);
  assign dispatch_ready = !full;
  assign alloc_rob_idx  = tail_idx;
  assign alloc          = dispatch_valid && dispatch_ready;

  // Commit fields stay zero whenever nothing retires so the RAT never sees a stale index.
  always_comb begin
    commit = '0;
    if (entries[head_idx].valid && entries[head_idx].done) begin
      commit.valid   = 1'b1;
      commit.rd_addr = entries[head_idx].rd_addr;
      commit.data    = entries[head_idx].data;
      commit.rob_idx = head_idx;
      commit.regf_we = entries[head_idx].regf_we && (entries[head_idx].rd_addr != 5'd0);
    end
  end

  assign commit_valid   = commit.valid;
  assign commit_rd_addr = commit.rd_addr;
  assign commit_data    = commit.data;
  assign commit_rob_idx = commit.rob_idx;
  assign commit_regf_we = commit.regf_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head <= '0;
      tail <= '0;
`ifdef ROB_FLUSH_EN
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head <= '0;
      tail <= '0;
`endif
    end else begin
      if (cdbus.valid && entries[cdbus.rob_idx].valid) begin
        entries[cdbus.rob_idx].done <= 1'b1;
        entries[cdbus.rob_idx].data <= cdbus.data;
      end
      if (commit.valid) begin
        entries[head_idx].valid <= 1'b0;
        head                    <= head + 1'b1;
      end
      // Written last so a (never legal) CDB hit on the fresh tail entry loses to the allocation.
      if (alloc) begin
        entries[tail_idx].valid   <= 1'b1;
        entries[tail_idx].done    <= 1'b0;
        entries[tail_idx].rd_addr <= dispatch_rd_addr;
        entries[tail_idx].regf_we <= dispatch_regf_we;
        entries[tail_idx].data    <= '0;
        tail                      <= tail + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for the reorder buffer: fill/full, out-of-order completion, x0, wrap, full+commit, flush.
module tb_rob;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatch_valid;
  logic [4:0]  dispatch_rd_addr;
  logic        dispatch_regf_we;
  logic        dispatch_ready;
  logic [4:0]  alloc_rob_idx;
  cdb          cdbus;
  logic        commit_valid;
  logic [4:0]  commit_rd_addr;
  logic [31:0] commit_data;
  logic [4:0]  commit_rob_idx;
  logic        commit_regf_we;
  logic        full;
  logic        empty;
`ifdef ROB_FLUSH_EN
  logic        flush;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rob #(.ROB_IDX_WIDTH(5)) dut (
    .clk(clk),
    .rst(rst),
    .dispatch_valid(dispatch_valid),
    .dispatch_rd_addr(dispatch_rd_addr),
    .dispatch_regf_we(dispatch_regf_we),
    .dispatch_ready(dispatch_ready),
    .alloc_rob_idx(alloc_rob_idx),
    .cdbus(cdbus),
    .commit_valid(commit_valid),
    .commit_rd_addr(commit_rd_addr),
    .commit_data(commit_data),
    .commit_rob_idx(commit_rob_idx),
    .commit_regf_we(commit_regf_we),
    .full(full),
    .empty(empty)
`ifdef ROB_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_valid   = 1'b0;
    dispatch_rd_addr = 5'd0;
    dispatch_regf_we = 1'b0;
    cdbus            = '0;
`ifdef ROB_FLUSH_EN
    flush            = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic we);
    dispatch_valid   = 1'b1;
    dispatch_rd_addr = rd;
    dispatch_regf_we = we;
    tick();
    dispatch_valid   = 1'b0;
  endtask

  task automatic broadcast(input logic [4:0] idx, input logic [31:0] data);
    cdbus.valid   = 1'b1;
    cdbus.rob_idx = idx;
    cdbus.data    = data;
    tick();
    cdbus = '0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b want 1", empty); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b want 0", full); end
    tests_run++; if (dispatch_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", dispatch_ready); end
    tests_run++; if (alloc_rob_idx !== 5'd0) begin tests_failed++; $display("FAIL reset_alloc got %0d want 0", alloc_rob_idx); end
    tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_commit_valid got %b want 0", commit_valid); end
    tests_run++;
    if ({commit_rd_addr, commit_data, commit_rob_idx, commit_regf_we} !== 43'd0) begin
      tests_failed++;
      $display("FAIL reset_commit_fields got rd=%0d data=%h idx=%0d we=%b want all 0",
               commit_rd_addr, commit_data, commit_rob_idx, commit_regf_we);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tests_run++;
      if (alloc_rob_idx !== 5'(i)) begin tests_failed++; $display("FAIL fill_alloc_idx got %0d want %0d", alloc_rob_idx, i); end
      dispatch(5'(i), 1'b1);
    end
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL fill_full got %b want 1", full); end
    tests_run++; if (dispatch_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_ready got %b want 0", dispatch_ready); end
    tests_run++; if (empty !== 1'b0) begin tests_failed++; $display("FAIL fill_empty got %b want 0", empty); end
    dispatch(5'd7, 1'b1);
    tests_run++; if (alloc_rob_idx !== 5'd0) begin tests_failed++; $display("FAIL fill_33rd_tail got %0d want 0", alloc_rob_idx); end
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL fill_33rd_full got %b want 1", full); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    dispatch(5'd5, 1'b1);
    dispatch(5'd6, 1'b1);
    broadcast(5'd1, 32'h0000_BEEF);
    tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL ooo_no_early_commit got %b want 0", commit_valid); end
    broadcast(5'd0, 32'h0000_1234);
    tests_run++;
    if ({commit_valid, commit_rd_addr, commit_data, commit_rob_idx, commit_regf_we} !== {1'b1, 5'd5, 32'h1234, 5'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL ooo_commit0 got v=%b rd=%0d data=%h idx=%0d we=%b want v=1 rd=5 data=1234 idx=0 we=1",
               commit_valid, commit_rd_addr, commit_data, commit_rob_idx, commit_regf_we);
    end
    tick();
    tests_run++;
    if ({commit_valid, commit_rd_addr, commit_data, commit_rob_idx} !== {1'b1, 5'd6, 32'hBEEF, 5'd1}) begin
      tests_failed++;
      $display("FAIL ooo_commit1 got v=%b rd=%0d data=%h idx=%0d want v=1 rd=6 data=beef idx=1",
               commit_valid, commit_rd_addr, commit_data, commit_rob_idx);
    end
    tick();
    tests_run++; if (commit_valid !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL ooo_drained got v=%b empty=%b want v=0 empty=1", commit_valid, empty); end
  endtask

  task automatic test_x0();
    do_reset();
    dispatch(5'd0, 1'b1);
    broadcast(5'd0, 32'h0000_0055);
    tests_run++; if (commit_valid !== 1'b1) begin tests_failed++; $display("FAIL x0_commit_valid got %b want 1", commit_valid); end
    tests_run++; if (commit_regf_we !== 1'b0) begin tests_failed++; $display("FAIL x0_regf_we got %b want 0", commit_regf_we); end
    tests_run++; if (commit_data !== 32'h55) begin tests_failed++; $display("FAIL x0_data got %h want 55", commit_data); end
    tick();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL x0_empty got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_data;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      tests_run++;
      if (alloc_rob_idx !== 5'(k % 32)) begin tests_failed++; $display("FAIL wrap_alloc_idx got %0d want %0d", alloc_rob_idx, k % 32); end
      dispatch(5'(k % 31 + 1), 1'b1);
      exp_q.push_back(32'(k * 3 + 7));
      broadcast(5'(k % 32), 32'(k * 3 + 7));
      exp_data = exp_q.pop_front();
      tests_run++;
      if (commit_valid !== 1'b1 || commit_rob_idx !== 5'(k % 32) || commit_data !== exp_data || commit_rd_addr !== 5'(k % 31 + 1)) begin
        tests_failed++;
        $display("FAIL wrap_commit got v=%b idx=%0d data=%h rd=%0d want v=1 idx=%0d data=%h rd=%0d",
                 commit_valid, commit_rob_idx, commit_data, commit_rd_addr, k % 32, exp_data, k % 31 + 1);
      end
      tick();
    end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_full_commit();
    do_reset();
    for (int i = 0; i < 32; i++) dispatch(5'(i % 31 + 1), 1'b1);
    broadcast(5'd0, 32'h0000_00A0);
    dispatch_valid   = 1'b1;
    dispatch_rd_addr = 5'd9;
    dispatch_regf_we = 1'b1;
    tests_run++; if (dispatch_ready !== 1'b0) begin tests_failed++; $display("FAIL fullc_ready got %b want 0", dispatch_ready); end
    tests_run++; if (commit_valid !== 1'b1 || commit_rob_idx !== 5'd0) begin tests_failed++; $display("FAIL fullc_commit got v=%b idx=%0d want v=1 idx=0", commit_valid, commit_rob_idx); end
    tick();
    tests_run++;
    if (full !== 1'b0 || dispatch_ready !== 1'b1 || alloc_rob_idx !== 5'd0) begin
      tests_failed++;
      $display("FAIL fullc_refused got full=%b ready=%b alloc=%0d want full=0 ready=1 alloc=0", full, dispatch_ready, alloc_rob_idx);
    end
    tick();
    dispatch_valid = 1'b0;
    tests_run++;
    if (full !== 1'b1 || alloc_rob_idx !== 5'd1) begin
      tests_failed++;
      $display("FAIL fullc_wrapped_alloc got full=%b alloc=%0d want full=1 alloc=1", full, alloc_rob_idx);
    end
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(5'(i + 1), 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL flush_empty got %b want 1", empty); end
    tests_run++; if (alloc_rob_idx !== 5'd0) begin tests_failed++; $display("FAIL flush_alloc got %0d want 0", alloc_rob_idx); end
    broadcast(5'd0, 32'h0000_0077);
    tests_run++; if (commit_valid !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL flush_late_cdb got v=%b empty=%b want v=0 empty=1", commit_valid, empty); end
  endtask
`endif

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_fill();
    test_out_of_order();
    test_x0();
    test_wrap();
    test_full_commit();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
